// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-memory loader: FSM states, sizes and the NOP fill word.
package prog_loader_pkg;

   localparam int unsigned PROG_ADDR_W = 5;
   localparam int unsigned MAX_WORDS   = 32;
   localparam logic [15:0] NOP_WORD    = 16'h3C00;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_COUNT = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_CSUM  = 3'd4,
      ST_ERR   = 3'd5
   } state_e;

   // States that consume stream bytes; the processor must not fetch during these.
   function automatic logic in_frame(input state_e st);
      return (st == ST_COUNT) || (st == ST_HI) || (st == ST_LO) || (st == ST_CSUM);
   endfunction

endpackage

// File: rtl/prog_loader_ram.sv
// Program RAM: synchronous write, asynchronous read, whole array refilled with FILL_WORD on reset.
module prog_ram
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = PROG_ADDR_W,
   parameter int unsigned DEPTH     = 2 ** ADDR_W,
   parameter logic [15:0] FILL_WORD = NOP_WORD
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata
);

   logic [15:0] mem_q [DEPTH];
   logic [15:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= FILL_WORD;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read sees the pre-edge contents, so a same-cycle write returns the old word.
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the program RAM; holds the core in reset until a good load.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame in progress; load_start opens a frame
// ST_COUNT | waiting for word count N (1..MAX_WORDS)
// ST_HI    | waiting for high byte of the next word
// ST_LO    | waiting for low byte; word is written on acceptance
// ST_CSUM  | waiting for checksum byte
// ST_ERR   | last frame failed; core held in reset until load_start
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = PROG_ADDR_W,
   parameter int unsigned DEPTH     = 2 ** ADDR_W,
   parameter logic [15:0] FILL_WORD = NOP_WORD
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              load_start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [15:0]       fetch_data,
   output logic              cpu_rstn,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [5:0]        word_cnt
);

   state_e            state_q, state_d;
   logic [5:0]        n_q, n_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [5:0]        word_cnt_q, word_cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              cpu_rstn_q, cpu_rstn_d;

   logic              accept;
   logic              ram_we;
   logic [15:0]       ram_rdata;

   assign busy       = in_frame(state_q);
   assign byte_ready = busy;
   assign accept     = byte_valid && byte_ready;

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      hi_d       = hi_q;
      csum_d     = csum_q;
      wr_addr_d  = wr_addr_q;
      word_cnt_d = word_cnt_q;
      done_d     = done_q;
      err_d      = err_q;
      cpu_rstn_d = cpu_rstn_q;
      ram_we     = 1'b0;

      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (load_start) begin
               state_d    = ST_COUNT;
               done_d     = 1'b0;
               err_d      = 1'b0;
               word_cnt_d = '0;
               wr_addr_d  = '0;
               csum_d     = '0;
               cpu_rstn_d = 1'b0;
            end
         end
         ST_COUNT: begin
            if (accept) begin
               if ((byte_data == 8'd0) || (byte_data > 8'(MAX_WORDS))) begin
                  state_d    = ST_ERR;
                  err_d      = 1'b1;
                  cpu_rstn_d = 1'b0;
               end else begin
                  n_d     = byte_data[5:0];
                  csum_d  = byte_data;
                  state_d = ST_HI;
               end
            end
         end
         ST_HI: begin
            if (accept) begin
               hi_d    = byte_data;
               csum_d  = csum_q + byte_data;
               state_d = ST_LO;
            end
         end
         ST_LO: begin
            if (accept) begin
               ram_we     = 1'b1;
               wr_addr_d  = wr_addr_q + 1'b1;
               word_cnt_d = word_cnt_q + 6'd1;
               csum_d     = csum_q + byte_data;
               state_d    = (word_cnt_q + 6'd1 == n_q) ? ST_CSUM : ST_HI;
            end
         end
         ST_CSUM: begin
            if (accept) begin
               if (8'(csum_q + byte_data) == 8'd0) begin
                  state_d    = ST_IDLE;
                  done_d     = 1'b1;
                  cpu_rstn_d = 1'b1;
               end else begin
                  state_d    = ST_ERR;
                  err_d      = 1'b1;
                  cpu_rstn_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         hi_q       <= '0;
         csum_q     <= '0;
         wr_addr_q  <= '0;
         word_cnt_q <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cpu_rstn_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         hi_q       <= hi_d;
         csum_q     <= csum_d;
         wr_addr_q  <= wr_addr_d;
         word_cnt_q <= word_cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cpu_rstn_q <= cpu_rstn_d;
      end
   end

   prog_ram #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .FILL_WORD(FILL_WORD)
   ) u_ram (
      .clk  (clk),
      .rstn (rstn),
      .we   (ram_we),
      .waddr(wr_addr_q),
      .wdata({hi_q, byte_data}),
      .raddr(fetch_addr),
      .rdata(ram_rdata)
   );

   assign fetch_data = (fetch_en && !busy) ? ram_rdata : 16'h0000;
   assign cpu_rstn   = cpu_rstn_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_cnt   = word_cnt_q;

endmodule
